echo_delay_ctrl: RTL and testbench

ECHO_DELAY_CTRL -- requirements
Module: echo_delay_ctrl

---
 rtl/echo_pkg.sv | 14 +
 rtl/rise_detect.sv | 23 ++
 rtl/echo_delay_ctrl.sv | 113 +++++++++++
 tb/tb_echo_delay_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared definitions for the echo delay-buffer controller.
// Buffer geometry defaults and the controller state encoding.
package echo_pkg;

    localparam int ADDR_W    = 13;
    localparam int MIN_DELAY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the ADC sample-ready level.
// History resets high so a level already high at reset is not an edge.
module rise_detect (
    input  logic sysclk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev;

    // one-cycle history of the input level
    always_ff @(posedge sysclk) begin
        if (reset) begin
            prev <= 1'b1;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/echo_delay_ctrl.sv
// Echo delay-buffer controller: one read then one write per sample,
// circular pointer over a latched delay length, FILL then RUN.
module echo_delay_ctrl #(
    parameter int ADDR_W    = echo_pkg::ADDR_W,
    parameter int MIN_DELAY = echo_pkg::MIN_DELAY
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              data_valid,
    input  logic [ADDR_W-1:0] delay_len,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    output logic              ram_wren,
    output logic              echo_en,
    output logic              out_load,
    output logic              busy,
    output logic              overrun
);

    import echo_pkg::*;

    localparam logic [ADDR_W-1:0] MIN_LEN = ADDR_W'(MIN_DELAY);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [ADDR_W-1:0] len, len_n;
    logic [ADDR_W-1:0] addr_n;
    logic              rd_n, wr_n, ovr_n;
    logic              ev, wrap;

    rise_detect u_rise (
        .sysclk (sysclk),
        .reset  (reset),
        .din    (data_valid),
        .rise   (ev)
    );

    assign wrap     = (ptr == len - ONE);
    assign busy     = ram_rden | ram_wren;
    assign out_load = ram_wren;
    assign echo_en  = (state == RUN);

    // next-state, pointer and strobe sequencing
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        len_n   = len;
        addr_n  = ram_addr;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        ovr_n   = overrun;
        if (ev && busy) begin
            ovr_n = 1'b1;
        end
        if (ram_rden) begin
            wr_n = 1'b1;
        end else if (ram_wren) begin
            ptr_n = wrap ? '0 : ptr + ONE;
            if (!enable) begin
                state_n = IDLE;
                ptr_n   = '0;
            end else if (state == FILL && wrap) begin
                state_n = RUN;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (ev && enable) begin
                        state_n = FILL;
                        len_n   = (delay_len > MIN_LEN) ? delay_len : MIN_LEN;
                        ptr_n   = '0;
                        addr_n  = '0;
                        rd_n    = 1'b1;
                    end
                end
                FILL, RUN: begin
                    if (!enable) begin
                        state_n = IDLE;
                        ptr_n   = '0;
                    end else if (ev) begin
                        addr_n = ptr;
                        rd_n   = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // state, pointer and registered outputs
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            len      <= MIN_LEN;
            ram_addr <= '0;
            ram_rden <= 1'b0;
            ram_wren <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            len      <= len_n;
            ram_addr <= addr_n;
            ram_rden <= rd_n;
            ram_wren <= wr_n;
            overrun  <= ovr_n;
        end
    end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Self-checking bench for echo_delay_ctrl.
// Directed scenarios plus randomized traffic against a queue-free ring model.
module tb_echo_delay_ctrl;

    localparam int AW  = 13;
    localparam int MIN = 2;

    logic          sysclk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          data_valid = 1'b0;
    logic [AW-1:0] delay_len = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_rden, ram_wren, echo_en;
    logic          out_load, busy, overrun;

    int errs = 0;
    int checks = 0;

    // reference model: 0 idle, 1 filling, 2 running
    int m_mode = 0;
    int m_len = MIN;
    int m_ptr = 0;

    logic [AW-1:0] last_addr;
    logic          last_echo;

    echo_delay_ctrl #(.ADDR_W(AW), .MIN_DELAY(MIN)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .enable     (enable),
        .data_valid (data_valid),
        .delay_len  (delay_len),
        .ram_addr   (ram_addr),
        .ram_rden   (ram_rden),
        .ram_wren   (ram_wren),
        .echo_en    (echo_en),
        .out_load   (out_load),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_event(output int ea, output bit ee);
        if (m_mode == 0) begin
            m_mode = 1;
            m_len  = (int'(delay_len) < MIN) ? MIN : int'(delay_len);
            m_ptr  = 0;
        end
        ea    = m_ptr;
        ee    = (m_mode == 2);
        m_ptr = (m_ptr + 1) % m_len;
        if (m_ptr == 0 && m_mode == 1) m_mode = 2;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
    endtask

    task automatic do_reset();
        @(posedge sysclk); #1;
        reset = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b0;
        m_mode = 0;
        m_ptr  = 0;
    endtask

    task automatic do_disable();
        @(posedge sysclk); #1 enable = 1'b0;
        repeat (2) @(posedge sysclk);
        #1 enable = 1'b1;
        m_mode = 0;
        m_ptr  = 0;
    endtask

    // one accepted sample event with its T+1..T+3 strobe checks
    task automatic sample_event(input string tag);
        int ea;
        bit ee;
        model_event(ea, ee);
        @(posedge sysclk); #1 data_valid = 1'b1;
        @(posedge sysclk); #1 data_valid = 1'b0;
        @(negedge sysclk);
        checks++;
        if (ram_rden !== 1'b1 || ram_wren !== 1'b0 || busy !== 1'b1 ||
            ram_addr !== AW'(ea)) begin
            errs++;
            $display("FAIL %s T+1: rden=%b wren=%b busy=%b addr=%0d, need 1 0 1 %0d",
                     tag, ram_rden, ram_wren, busy, ram_addr, ea);
        end
        @(posedge sysclk); #1;
        @(negedge sysclk);
        last_addr = ram_addr;
        last_echo = echo_en;
        checks++;
        if (ram_wren !== 1'b1 || out_load !== 1'b1 || ram_rden !== 1'b0 ||
            ram_addr !== AW'(ea) || echo_en !== ee) begin
            errs++;
            $display("FAIL %s T+2: wren=%b load=%b rden=%b addr=%0d echo=%b, need 1 1 0 %0d %b",
                     tag, ram_wren, out_load, ram_rden, ram_addr, echo_en, ea, ee);
        end
        @(posedge sysclk); #1;
        @(negedge sysclk);
        checks++;
        if (busy !== 1'b0 || ram_wren !== 1'b0 || ram_rden !== 1'b0) begin
            errs++;
            $display("FAIL %s T+3: busy=%b wren=%b rden=%b, need 0 0 0",
                     tag, busy, ram_wren, ram_rden);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        checks++;
        if (ram_addr !== '0 || ram_rden !== 1'b0 || ram_wren !== 1'b0 ||
            out_load !== 1'b0 || echo_en !== 1'b0 || busy !== 1'b0 ||
            overrun !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: addr=%0d rden=%b wren=%b load=%b echo=%b busy=%b ovr=%b, need all 0",
                     ram_addr, ram_rden, ram_wren, out_load, echo_en, busy, overrun);
        end
        #1 reset = 1'b0;
        m_mode = 0;
        m_ptr  = 0;
    endtask

    task automatic test_basic();
        int exp_a[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        do_reset();
        enable = 1'b1;
        delay_len = AW'(4);
        for (int i = 0; i < 10; i++) begin
            sample_event("basic");
            checks++;
            if (last_addr !== AW'(exp_a[i]) || last_echo !== (i >= 4)) begin
                errs++;
                $display("FAIL basic_seq ev%0d: addr=%0d echo=%b, need %0d %b",
                         i + 1, last_addr, last_echo, exp_a[i], (i >= 4));
            end
            idle(46);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        enable = 1'b1;
        delay_len = '0;
        for (int i = 0; i < 5; i++) begin
            sample_event("clamp");
            checks++;
            if (last_addr !== AW'(i % 2) || last_echo !== (i >= 2)) begin
                errs++;
                $display("FAIL clamp ev%0d: addr=%0d echo=%b, need %0d %b",
                         i + 1, last_addr, last_echo, i % 2, (i >= 2));
            end
            idle(3);
        end
    endtask

    task automatic test_overrun();
        int ea;
        bit ee;
        do_reset();
        enable = 1'b1;
        delay_len = AW'(4);
        model_event(ea, ee);
        @(posedge sysclk); #1 data_valid = 1'b1;
        @(posedge sysclk); #1 data_valid = 1'b0;
        @(negedge sysclk);
        checks++;
        if (ram_rden !== 1'b1 || ram_addr !== AW'(ea)) begin
            errs++;
            $display("FAIL ovr_first_read: rden=%b addr=%0d, need 1 %0d", ram_rden, ram_addr, ea);
        end
        @(posedge sysclk); #1 data_valid = 1'b1;
        @(negedge sysclk);
        checks++;
        if (ram_wren !== 1'b1 || overrun !== 1'b0) begin
            errs++;
            $display("FAIL ovr_write: wren=%b ovr=%b, need 1 0", ram_wren, overrun);
        end
        @(posedge sysclk); #1 data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            checks++;
            if (ram_rden !== 1'b0 || ram_wren !== 1'b0 || overrun !== 1'b1) begin
                errs++;
                $display("FAIL ovr_drop c%0d: rden=%b wren=%b ovr=%b, need 0 0 1",
                         i, ram_rden, ram_wren, overrun);
            end
            @(posedge sysclk); #1;
        end
        sample_event("ovr_next");
        idle(5);
        sample_event("ovr_next");
        checks++;
        if (overrun !== 1'b1) begin
            errs++;
            $display("FAIL ovr_sticky: ovr=%b, need 1", overrun);
        end
        do_reset();
        @(negedge sysclk);
        checks++;
        if (overrun !== 1'b0) begin
            errs++;
            $display("FAIL ovr_clear: ovr=%b, need 0", overrun);
        end
    endtask

    task automatic test_disable();
        int ea;
        bit ee;
        do_reset();
        enable = 1'b1;
        delay_len = AW'(2);
        sample_event("dis_fill");
        sample_event("dis_fill");
        model_event(ea, ee);
        @(posedge sysclk); #1 data_valid = 1'b1;
        @(posedge sysclk); #1 data_valid = 1'b0; enable = 1'b0;
        @(negedge sysclk);
        checks++;
        if (ram_rden !== 1'b1 || ram_addr !== AW'(ea)) begin
            errs++;
            $display("FAIL dis_read: rden=%b addr=%0d, need 1 %0d", ram_rden, ram_addr, ea);
        end
        @(posedge sysclk); #1;
        @(negedge sysclk);
        checks++;
        if (ram_wren !== 1'b1 || out_load !== 1'b1 || echo_en !== 1'b1) begin
            errs++;
            $display("FAIL dis_write: wren=%b load=%b echo=%b, need 1 1 1",
                     ram_wren, out_load, echo_en);
        end
        @(posedge sysclk); #1;
        @(negedge sysclk);
        checks++;
        if (echo_en !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL dis_idle: echo=%b busy=%b, need 0 0", echo_en, busy);
        end
        m_mode = 0;
        m_ptr  = 0;
        @(posedge sysclk); #1 data_valid = 1'b1;
        @(posedge sysclk); #1 data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            checks++;
            if (ram_rden !== 1'b0 || ram_wren !== 1'b0 || overrun !== 1'b0) begin
                errs++;
                $display("FAIL dis_ignore c%0d: rden=%b wren=%b ovr=%b, need 0 0 0",
                         i, ram_rden, ram_wren, overrun);
            end
            @(posedge sysclk); #1;
        end
        enable = 1'b1;
        sample_event("dis_restart");
        checks++;
        if (last_addr !== '0 || last_echo !== 1'b0) begin
            errs++;
            $display("FAIL dis_restart_addr: addr=%0d echo=%b, need 0 0", last_addr, last_echo);
        end
    endtask

    task automatic test_reset_behaviour();
        int seen;
        @(posedge sysclk); #1;
        data_valid = 1'b1;
        reset = 1'b1;
        enable = 1'b1;
        delay_len = AW'(4);
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b0;
        m_mode = 0;
        m_ptr  = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sysclk);
            if (ram_rden !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errs++;
            $display("FAIL rst_level_high: strobe cycles=%0d, need 0", seen);
        end
        @(posedge sysclk); #1 data_valid = 1'b0;
        sample_event("rst_first");
        idle(3);
        @(posedge sysclk); #1 data_valid = 1'b1;
        @(posedge sysclk); #1 data_valid = 1'b0; reset = 1'b1;
        @(negedge sysclk);
        checks++;
        if (ram_rden !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid_read: rden=%b, need 1", ram_rden);
        end
        @(posedge sysclk); #1 reset = 1'b0;
        @(negedge sysclk);
        checks++;
        if (ram_wren !== 1'b0 || out_load !== 1'b0 || busy !== 1'b0 || ram_rden !== 1'b0) begin
            errs++;
            $display("FAIL rst_abort: wren=%b load=%b busy=%b rden=%b, need 0 0 0 0",
                     ram_wren, out_load, busy, ram_rden);
        end
        m_mode = 0;
        m_ptr  = 0;
        idle(2);
        sample_event("rst_after");
        checks++;
        if (last_addr !== '0) begin
            errs++;
            $display("FAIL rst_restart_addr: addr=%0d, need 0", last_addr);
        end
    endtask

    task automatic test_delay_change();
        int exp_a[7] = '{0, 1, 2, 3, 4, 5, 0};
        do_reset();
        enable = 1'b1;
        delay_len = AW'(4);
        for (int i = 0; i < 6; i++) begin
            sample_event("dly_old");
            idle(2);
        end
        delay_len = AW'(6);
        for (int i = 0; i < 4; i++) begin
            sample_event("dly_held");
            checks++;
            if (last_addr !== AW'((i + 2) % 4)) begin
                errs++;
                $display("FAIL dly_held ev%0d: addr=%0d, need %0d", i, last_addr, (i + 2) % 4);
            end
            idle(2);
        end
        do_disable();
        for (int i = 0; i < 7; i++) begin
            sample_event("dly_new");
            checks++;
            if (last_addr !== AW'(exp_a[i])) begin
                errs++;
                $display("FAIL dly_new ev%0d: addr=%0d, need %0d", i, last_addr, exp_a[i]);
            end
            idle(2);
        end
    endtask

    task automatic test_random();
        do_reset();
        enable = 1'b1;
        delay_len = AW'($urandom_range(0, 9));
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) delay_len = AW'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) do_disable();
            sample_event("rand");
            idle($urandom_range(0, 6));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_overrun();
        test_disable();
        test_reset_behaviour();
        test_delay_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
